// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, FSM state encoding and the op-field width.
// Build option: MULDIV_DIVIDE_EN enables the SDIV/UDIV operations.
package muldiv_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL   = 3'd0,
        OP_SMULH = 3'd1,
        OP_UMULH = 3'd2,
        OP_SDIV  = 3'd3,
        OP_UDIV  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // An op is legal when it names an operation present in this build.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
`ifdef MULDIV_DIVIDE_EN
        return (op <= OP_UDIV);
`else
        return (op <= OP_UMULH);
`endif
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the muldiv datapath, retiring
// BITS_PER_CYCLE bits: shift-add for multiply (multiplier consumed from
// the LSB of lo) or restoring shift-subtract for divide (dividend consumed
// from the MSB of lo, quotient bits shifted in at the LSB).
// Build option: MULDIV_DIVIDE_EN adds the divide path and its is_div_i port.
module muldiv_step #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
`ifdef MULDIV_DIVIDE_EN
    input  logic             is_div_i,
`endif
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] acc_v;
    logic [WIDTH-1:0] lo_v;
    logic [WIDTH:0]   ext_v;
`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH:0]   diff_v;
`endif

    // Chain BITS_PER_CYCLE single-bit add/subtract steps.
    always_comb begin
        acc_v = acc_i;
        lo_v  = lo_i;
        ext_v = '0;
`ifdef MULDIV_DIVIDE_EN
        diff_v = '0;
`endif
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
`ifdef MULDIV_DIVIDE_EN
            if (is_div_i) begin
                // Remainder stays below the divisor, so WIDTH+1 bits hold the
                // shifted value and the sign of the trial difference.
                ext_v  = {acc_v, lo_v[WIDTH-1]};
                diff_v = ext_v - {1'b0, m_i};
                if (!diff_v[WIDTH]) begin
                    acc_v = diff_v[WIDTH-1:0];
                end else begin
                    acc_v = ext_v[WIDTH-1:0];
                end
                lo_v = {lo_v[WIDTH-2:0], ~diff_v[WIDTH]};
            end else begin
`endif
                ext_v = {1'b0, acc_v} + (lo_v[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});
                acc_v = ext_v[WIDTH:1];
                lo_v  = {ext_v[0], lo_v[WIDTH-1:1]};
`ifdef MULDIV_DIVIDE_EN
            end
`endif
        end
        acc_o = acc_v;
        lo_o  = lo_v;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. Operand magnitudes and the result sign are
// latched on accept; RUN iterates WIDTH/BITS_PER_CYCLE times through
// muldiv_step; FIXUP applies the sign and selects the result; DONE is
// followed by a registered one-cycle done pulse.
// Build option: MULDIV_DIVIDE_EN enables SDIV/UDIV; otherwise ops 3 and 4
// are reported as illegal.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             illegal
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              neg_q, neg_d;
    logic              ill_q, ill_d;
    logic              dz_q, dz_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic [WIDTH-1:0]  acc_step;
    logic [WIDTH-1:0]  lo_step;
    logic              op_ok;

    // Magnitude of a two's-complement value; the most negative value maps to
    // itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    // Sign-correct the double-width accumulator and pick the result half.
    function automatic logic [WIDTH-1:0] fix_result(
        input logic [OP_W-1:0]  opv,
        input logic             neg,
        input logic             ill,
        input logic             dz,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        logic [2*WIDTH-1:0] p;
        p = {hi, lo};
        if (neg) begin
            p = ~p + (2*WIDTH)'(1);
        end
        if (ill || dz) begin
            return '0;
        end
        case (opv)
            OP_SMULH, OP_UMULH: return p[2*WIDTH-1:WIDTH];
            OP_MUL, OP_SDIV, OP_UDIV: return p[WIDTH-1:0];
            default: return '0;
        endcase
    endfunction

    assign op_ok = op_legal(op);

    muldiv_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
`ifdef MULDIV_DIVIDE_EN
        .is_div_i (op_q == OP_SDIV || op_q == OP_UDIV),
`endif
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .acc_o    (acc_step),
        .lo_o     (lo_step)
    );

    // Next-state, datapath loads and output pulses for each FSM state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        m_d       = m_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        ill_d     = ill_q;
        dz_d      = dz_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    acc_d = '0;
                    ill_d = ~op_ok;
                    neg_d = 1'b0;
                    dz_d  = 1'b0;
                    m_d   = operand_a;
                    lo_d  = operand_b;
                    case (op)
                        OP_SMULH: begin
                            m_d   = mag(operand_a);
                            lo_d  = mag(operand_b);
                            neg_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        end
`ifdef MULDIV_DIVIDE_EN
                        OP_SDIV: begin
                            m_d   = mag(operand_b);
                            lo_d  = mag(operand_a);
                            neg_d = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                            dz_d  = (operand_b == '0);
                        end
                        OP_UDIV: begin
                            m_d   = operand_b;
                            lo_d  = operand_a;
                            dz_d  = (operand_b == '0);
                        end
`endif
                        default: begin
                        end
                    endcase
                    if (!op_ok) begin
                        m_d  = '0;
                        lo_d = '0;
                    end
                    state_d = op_ok ? ST_RUN : ST_FIXUP;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                result_d = fix_result(op_q, neg_q, ill_q, dz_q, acc_q, lo_q);
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done_d    = 1'b1;
                illegal_d = ill_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            ill_q     <= 1'b0;
            dz_q      <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            ill_q     <= ill_d;
            dz_q      <= dz_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_FIXUP);
    assign stall   = (start && (state_q == ST_IDLE)) || busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 64-bit radix-2 instance and a 32-bit
// radix-16 instance on a shared clock and reset.
// Build option: MULDIV_DIVIDE_EN selects the divide vectors; otherwise the
// divide ops are expected to report illegal.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] result;
    logic        busy;
    logic        done;
    logic        stall;
    logic        illegal;

    logic        start2;
    logic [2:0]  op2;
    logic [31:0] a2;
    logic [31:0] b2;
    logic [31:0] result2;
    logic        busy2;
    logic        done2;
    logic        stall2;
    logic        illegal2;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (a),
        .operand_b (b),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .illegal   (illegal)
    );

    muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .op        (op2),
        .operand_a (a2),
        .operand_b (b2),
        .result    (result2),
        .busy      (busy2),
        .done      (done2),
        .stall     (stall2),
        .illegal   (illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble the operands after accept, wait for done.
    task automatic run_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                          output logic [63:0] res, output logic ill, output int lat,
                          output int bcnt, output logic st);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        #1 st = stall;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~x;
        b     = y ^ 64'h5a5a;
        op    = 3'd2;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        res = result;
        ill = illegal;
    endtask

    logic [63:0] r;
    logic        il;
    logic        st;
    int          lat;
    int          bc;
    int          seen;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        start2 = 1'b0;
        op2    = 3'd0;
        a2     = '0;
        b2     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic multiply, latency and busy duration
        run_op(3'd0, 64'd7, 64'd6, r, il, lat, bc, st);
        chk("mul_7x6", r, 64'd42);
        chk("mul_lat", 64'(lat), 64'd66);
        chk("mul_busy", 64'(bc), 64'd65);
        chk("mul_ill", 64'(il), 64'd0);
        chk("mul_stall", 64'(st), 64'd1);
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("result_held", result, 64'd42);

        run_op(3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, il, lat, bc, st);
        chk("mul_32x32", r, 64'hFFFF_FFFE_0000_0001);

        run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, r, il, lat, bc, st);
        chk("smulh_m1x1", r, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("smulh_lat", 64'(lat), 64'd66);
        run_op(3'd1, 64'h4000_0000_0000_0000, 64'd4, r, il, lat, bc, st);
        chk("smulh_pos", r, 64'd1);
        run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, r, il, lat, bc, st);
        chk("smulh_m3x5", r, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, il, lat, bc, st);
        chk("umulh_ones_x2", r, 64'd1);
        run_op(3'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, il, lat, bc, st);
        chk("umulh_big", r, 64'h4000_0000_0000_0000);

`ifdef MULDIV_DIVIDE_EN
        run_op(3'd4, 64'd100, 64'd7, r, il, lat, bc, st);
        chk("udiv_100_7", r, 64'd14);
        chk("udiv_lat", 64'(lat), 64'd66);
        run_op(3'd3, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, il, lat, bc, st);
        chk("sdiv_m100_7", r, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op(3'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, il, lat, bc, st);
        chk("sdiv_min_m1", r, 64'h8000_0000_0000_0000);
        run_op(3'd4, 64'd5, 64'd0, r, il, lat, bc, st);
        chk("udiv_by0", r, 64'd0);
        chk("udiv_by0_ill", 64'(il), 64'd0);
        chk("udiv_by0_lat", 64'(lat), 64'd66);
`else
        run_op(3'd4, 64'd100, 64'd7, r, il, lat, bc, st);
        chk("udiv_off", r, 64'd0);
        chk("udiv_off_ill", 64'(il), 64'd1);
        chk("udiv_off_lat", 64'(lat), 64'd2);
        run_op(3'd3, 64'd100, 64'd7, r, il, lat, bc, st);
        chk("sdiv_off_ill", 64'(il), 64'd1);
`endif

        // Illegal op code
        run_op(3'd6, 64'd3, 64'd4, r, il, lat, bc, st);
        chk("ill6_result", r, 64'd0);
        chk("ill6_flag", 64'(il), 64'd1);
        chk("ill6_lat", 64'(lat), 64'd2);

        // Start pulsed mid-RUN is ignored
        @(negedge clk);
        op    = 3'd0;
        a     = 64'd7;
        b     = 64'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        op    = 3'd2;
        a     = 64'd100;
        b     = 64'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 11;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ignore_result", result, 64'd42);
        chk("ignore_lat", 64'(lat), 64'd66);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("ignore_no_queue", 64'(seen), 64'd0);

        // Reset asserted in RUN cycle 30
        @(negedge clk);
        op    = 3'd0;
        a     = 64'd5;
        b     = 64'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_op(3'd0, 64'd3, 64'd3, r, il, lat, bc, st);
        chk("after_rst_mul", r, 64'd9);
        chk("after_rst_lat", 64'(lat), 64'd66);

        // 32-bit, 4 bits per cycle instance
        @(negedge clk);
        op2    = 3'd0;
        a2     = 32'h0000_FFFF;
        b2     = 32'h0000_FFFF;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        lat    = 0;
        while (!done2 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w32_mul", 64'(result2), 64'h0000_0000_FFFE_0001);
        chk("w32_lat", 64'(lat), 64'd10);
        chk("w32_ill", 64'(illegal2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter BITS_PER_CYCLE, default 1: bits retired per iteration. Legal values are 1, 2 and 4, and WIDTH SHALL be divisible by it.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  3  operation: MUL=0, SMULH=1, UMULH=2, SDIV=3, UDIV=4; 5-7 are illegal.
REQ-007 operand_a  input  WIDTH  multiplicand or dividend.
REQ-008 operand_b  input  WIDTH  multiplier or divisor.
REQ-009 result  output  WIDTH  registered result, held until the next accepted start.
REQ-010 busy  output  1  high in RUN and FIXUP.
REQ-011 done  output  1  one-cycle pulse when result becomes valid.
REQ-012 stall  output  1  combinational: (start & IDLE) | busy; stalls the fetch/decode stages.
REQ-013 illegal  output  1  registered; high with done when the op is illegal or compiled out.

Function
REQ-014 The unit SHALL be an FSM with states IDLE, RUN, FIXUP and DONE.
REQ-015 In IDLE with start=1, the unit SHALL latch op, the operand magnitudes and the result sign, clear the iteration counter, and enter RUN.
REQ-016 RUN SHALL last exactly N = WIDTH/BITS_PER_CYCLE cycles. Each cycle processes BITS_PER_CYCLE bits: shift-add for multiply, restoring shift-subtract for divide. The counter SHALL be ceil(log2(N+1)) bits wide, and the FSM enters FIXUP when counter == N-1.
REQ-017 FIXUP (1 cycle) SHALL apply two's-complement negation where signed, select the result half or the quotient, write result, and go to DONE.
REQ-018 DONE (1 cycle) SHALL assert done and return to IDLE.
REQ-019 Total latency from the start-accept edge to done high SHALL be N+2 cycles.
REQ-020 MUL SHALL return the low WIDTH bits of the 2*WIDTH-bit product; sign is irrelevant.
REQ-021 SMULH SHALL return the high WIDTH bits of the signed product.
REQ-022 UMULH SHALL return the high WIDTH bits of the unsigned product.
REQ-023 SDIV SHALL return the quotient truncated toward zero. UDIV SHALL return the unsigned quotient. No remainder is output.
REQ-024 Divide by zero (SDIV or UDIV) SHALL return 0 with illegal=0, taking the full N+2 latency.
REQ-025 SDIV of the most negative value by -1 SHALL return the most negative value, with no trap.
REQ-026 start while busy, or while in DONE, SHALL be ignored. The in-flight operation is unaffected, and the unit does not queue the request.
REQ-027 An illegal op SHALL skip RUN (IDLE->FIXUP->DONE) and set result=0 and illegal=1.
REQ-028 Operand changes after the accept edge SHALL NOT affect the result.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, counter=0, result=0, done=0, busy=0 and illegal=0; internal accumulators SHALL also clear to 0.
REQ-030 Reset during RUN or FIXUP SHALL abort the operation with no done pulse. The first start after deassertion is accepted normally.

Configuration
REQ-031 Macro MULDIV_DIVIDE_EN defined: SDIV and UDIV are implemented per REQ-023 to REQ-025.
REQ-032 Macro MULDIV_DIVIDE_EN undefined: the divide datapath is absent, and ops 3 and 4 are treated as illegal per REQ-027. Multiply behaviour and latency are unchanged.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op encoding enum, the FSM state enum and the op-width constant; the datapath top-level imports it.
REQ-034 The single combinational iteration (one BITS_PER_CYCLE add/subtract step) SHALL be sub-module muldiv_step. muldiv_unit owns the FSM, counter, registers and sign fixup.

Verification (WIDTH=64, BITS_PER_CYCLE=1 unless stated)
REQ-035 MUL with 7, 6: result=42, done exactly 66 cycles after accept, busy high for 65 cycles.
REQ-036 SMULH with -1, 1: result=all ones. UMULH with all ones, 2: result=1.
REQ-037 With the macro defined:
- UDIV 100/7 gives 14.
- SDIV -100/7 gives -14.
- SDIV 0x8000...0/-1 gives 0x8000...0.
- UDIV 5/0 gives 0 with illegal=0.
REQ-038 Reset asserted at RUN cycle 30: no done pulse. A following MUL 3*3 gives 9 with normal latency.
REQ-039 start pulsed at RUN cycle 10 with different operands: ignored, and the original result is returned. op=6 gives done 2 cycles after accept, illegal=1, result=0.
REQ-040 WIDTH=32, BITS_PER_CYCLE=4: MUL 0xFFFF x 0xFFFF gives 0xFFFE0001, done 10 cycles after accept.
